spi_cmd_engine: RTL and testbench
=================================

SPI_CMD_ENGINE -- requirements
Module: spi_cmd_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, framebuffer address width; legal range 9..12.
REQ-002 SHALL have parameter DEPTH, default 640, number of valid framebuffer words; DEPTH <= 2**ADDR_W.
REQ-003 SHALL have parameter STATE_W, default 16, width of the game-state output; legal range 1..16.
REQ-004 SHALL have parameter SCORE_W, default 10, width of the score output; legal range 8..10.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 cs  input  1  SPI chip select, active-low, asynchronous to clk; frame ends on rising edge.
REQ-009 command, databyte1, databyte2  input  8 each  shift-register bytes, stable while cs high.
REQ-010 we  output  1  framebuffer write strobe, one word per cycle.
REQ-011 waddr  output  ADDR_W  framebuffer write address.
REQ-012 wdata  output  8  framebuffer write data.
REQ-013 score  output  SCORE_W  registered score.
REQ-014 state  output  STATE_W  registered game state.
REQ-015 busy  output  1  high while a FILL/CLEAR burst is in progress or a frame is pending.
REQ-016 err  output  1  sticky error flag: bad opcode, out-of-range WRITE, or dropped frame.

Function
REQ-017 cs SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized cs SHALL generate a one-cycle frame_done pulse.
REQ-018 On frame_done, the three bytes SHALL be captured; the first we SHALL assert exactly 3 clk cycles after the first clk edge that samples cs high.
REQ-019 Opcode = command[7:4]; hi = command[3:0]; addr = {hi, databyte1} truncated to ADDR_W.
REQ-020 0x0 NOP: no effect.
REQ-021 0x1 WRITE: one we cycle, waddr=addr, wdata=databyte2; addr >= DEPTH: no write, err set.
REQ-022 0x2 SET_COLOR: internal color register = databyte2; no write.
REQ-023 0x3 FILL: databyte2+1 consecutive writes (1..256) of color starting at addr; address wraps from DEPTH-1 to 0; start addr >= DEPTH: no write, err set.
REQ-024 0x4 CLEAR: DEPTH writes of color, addresses 0..DEPTH-1, one per cycle.
REQ-025 0x5 SET_SCORE: score = addr[SCORE_W-1:0], updated on the cycle after capture.
REQ-026 0x6 SET_STATE: state = {databyte1, databyte2}[STATE_W-1:0], updated on the cycle after capture.
REQ-027 Opcodes 0x7..0xF: no effect except err set.
REQ-028 FSM states: IDLE, EXEC (single-cycle commands), BURST (FILL/CLEAR); IDLE->EXEC on frame capture; EXEC->BURST for FILL/CLEAR, else ->IDLE; BURST->IDLE after the last write, or ->EXEC when a frame is pending.
REQ-029 A single-entry pending buffer SHALL hold one frame arriving during BURST; it is executed directly after BURST with no idle cycle.
REQ-030 A frame arriving while the pending buffer is full SHALL be dropped and err set; the in-progress burst is unaffected.
REQ-031 we SHALL be high exactly once per word written; waddr/wdata are valid only while we is high and hold their last value otherwise.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 Reset SHALL force we=0, waddr=0, wdata=0, score=0, state=0, busy=0, err=0, color=0, pending buffer empty, FSM=IDLE, and synchronizer flops to 1 (cs idle).
REQ-034 Reset asserted mid-burst SHALL abort it immediately (we low asynchronously); no write resumes after release.

Structure
REQ-035 Shared package gfx_cmd_pkg SHALL hold the opcode enum, the FSM state typedef, and the default-parameter constants.
REQ-036 The cs synchronizer and edge detector SHALL be a separate sub-module, sync_rise.

Verification
REQ-037 WRITE: cmd=0x12, db1=0x34, db2=0xAB -> one we, waddr=0x234, wdata=0xAB, 3 cycles after cs rise.
REQ-038 SET_COLOR 0x0F, then FILL cmd=0x32, db1=0x7E, db2=0x04 (start 0x27E) -> 5 writes of 0x0F at 0x27E, 0x27F, 0x000, 0x001, 0x002 (wrap at DEPTH=640).
REQ-039 CLEAR, then a SET_SCORE frame during the burst -> 640 contiguous we cycles, then score updates with no gap; a third frame during the burst -> dropped, err=1.
REQ-040 WRITE with addr=0x2FF (>= DEPTH) -> no we, err=1; opcode 0x9 -> err=1, no outputs change.
REQ-041 Reset pulse at write 100 of CLEAR -> we low immediately, all outputs 0, no writes after release until a new frame.

Source files
------------

// File: rtl/gfx_cmd_pkg.sv
// Shared types and default parameters for the SPI graphics command engine.
package gfx_cmd_pkg;

    localparam int unsigned DEF_ADDR_W  = 10;
    localparam int unsigned DEF_DEPTH   = 640;
    localparam int unsigned DEF_STATE_W = 16;
    localparam int unsigned DEF_SCORE_W = 10;

    typedef enum logic [3:0] {
        OP_NOP       = 4'h0,
        OP_WRITE     = 4'h1,
        OP_SET_COLOR = 4'h2,
        OP_FILL      = 4'h3,
        OP_CLEAR     = 4'h4,
        OP_SET_SCORE = 4'h5,
        OP_SET_STATE = 4'h6
    } opcode_t;

    typedef logic [1:0] fsm_t;
    localparam fsm_t S_IDLE  = 2'd0;
    localparam fsm_t S_EXEC  = 2'd1;
    localparam fsm_t S_BURST = 2'd2;

    typedef struct packed {
        logic [7:0] command;
        logic [7:0] db1;
        logic [7:0] db2;
    } frame_t;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for an asynchronous level plus rising-edge pulse.
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise_c
);

    logic s1, s2, s3;

    // Flops idle high so a held-high input after reset never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/spi_cmd_engine.sv
// Decodes SPI command frames into framebuffer writes, score and game-state updates.
module spi_cmd_engine
    import gfx_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned STATE_W = DEF_STATE_W,
    parameter int unsigned SCORE_W = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic [7:0]         command,
    input  logic [7:0]         databyte1,
    input  logic [7:0]         databyte2,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [7:0]         wdata,
    output logic [SCORE_W-1:0] score,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               err
);

    logic   frame_done_c;
    frame_t frame_c;

    sync_rise u_sync (
        .clk    (clk),
        .reset  (reset),
        .d      (cs),
        .rise_c (frame_done_c)
    );

    assign frame_c = {command, databyte1, databyte2};

    fsm_t              fsm_q, fsm_d;
    frame_t            cur_q, cur_d, pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [7:0]        color_q, color_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_d, busy_d, err_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [7:0]        wdata_d;
    logic [SCORE_W-1:0] score_d;
    logic [STATE_W-1:0] state_d;
    logic              take_pend, took_frame;

    opcode_t           op;
    logic [ADDR_W-1:0] cur_addr;
    logic              addr_ok;

    assign op       = opcode_t'(cur_q.command[7:4]);
    assign cur_addr = ADDR_W'({cur_q.command[3:0], cur_q.db1});
    assign addr_ok  = 32'(cur_addr) < DEPTH;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (32'(a) == DEPTH - 1) ? '0 : a + ADDR_W'(1);
    endfunction

    // Next-state and next-output logic; cnt counts writes still owed by the burst.
    always_comb begin
        fsm_d      = fsm_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        color_d    = color_q;
        baddr_d    = baddr_q;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        waddr_d    = waddr;
        wdata_d    = wdata;
        score_d    = score;
        state_d    = state;
        err_d      = err;
        take_pend  = 1'b0;
        took_frame = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (pend_vld_q) begin
                    cur_d     = pend_q;
                    take_pend = 1'b1;
                    fsm_d     = S_EXEC;
                end else if (frame_done_c) begin
                    cur_d      = frame_c;
                    took_frame = 1'b1;
                    fsm_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                fsm_d = S_IDLE;
                case (op)
                    OP_NOP: ;
                    OP_WRITE: begin
                        if (addr_ok) begin
                            we_d    = 1'b1;
                            waddr_d = cur_addr;
                            wdata_d = cur_q.db2;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_SET_COLOR: color_d = cur_q.db2;
                    OP_FILL: begin
                        if (addr_ok) begin
                            we_d    = 1'b1;
                            waddr_d = cur_addr;
                            wdata_d = color_q;
                            baddr_d = wrap_inc(cur_addr);
                            cnt_d   = ADDR_W'(cur_q.db2);
                            if (cur_q.db2 != 8'd0) fsm_d = S_BURST;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        we_d    = 1'b1;
                        waddr_d = '0;
                        wdata_d = color_q;
                        baddr_d = wrap_inc('0);
                        cnt_d   = ADDR_W'(DEPTH - 1);
                        if (DEPTH > 1) fsm_d = S_BURST;
                    end
                    OP_SET_SCORE: score_d = SCORE_W'({cur_q.command[3:0], cur_q.db1});
                    OP_SET_STATE: state_d = STATE_W'({cur_q.db1, cur_q.db2});
                    default:      err_d   = 1'b1;
                endcase
            end
            S_BURST: begin
                we_d    = 1'b1;
                waddr_d = baddr_q;
                wdata_d = color_q;
                baddr_d = wrap_inc(baddr_q);
                cnt_d   = cnt_q - ADDR_W'(1);
                if (cnt_q == ADDR_W'(1)) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase

        // A pending frame runs straight after the current command, no idle cycle.
        if (fsm_q != S_IDLE && fsm_d == S_IDLE && pend_vld_q) begin
            cur_d     = pend_q;
            take_pend = 1'b1;
            fsm_d     = S_EXEC;
        end

        if (take_pend) pend_vld_d = 1'b0;

        if (frame_done_c && !took_frame) begin
            if (!pend_vld_q || take_pend) begin
                pend_d     = frame_c;
                pend_vld_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        busy_d = (fsm_d == S_BURST) || pend_vld_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q      <= S_IDLE;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            color_q    <= '0;
            baddr_q    <= '0;
            cnt_q      <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            score      <= '0;
            state      <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            color_q    <= color_d;
            baddr_q    <= baddr_d;
            cnt_q      <= cnt_d;
            we         <= we_d;
            waddr      <= waddr_d;
            wdata      <= wdata_d;
            score      <= score_d;
            state      <= state_d;
            busy       <= busy_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Self-checking bench for spi_cmd_engine: write scoreboard, vector table, burst/reset corners.
module tb_spi_cmd_engine;

    localparam int DEPTH = 640;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [7:0]  command, databyte1, databyte2;
    logic        we;
    logic [9:0]  waddr;
    logic [7:0]  wdata;
    logic [9:0]  score;
    logic [15:0] state;
    logic        busy;
    logic        err;

    spi_cmd_engine dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .command   (command),
        .databyte1 (databyte1),
        .databyte2 (databyte2),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .score     (score),
        .state     (state),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        string      name;
        logic [7:0] cmd;
        logic [7:0] db1;
        logic [7:0] db2;
        int         exp_score;
        int         exp_state;
        int         exp_err;
    } vec_t;

    wr_t        exp_q[$];
    logic [7:0] m_color;
    int         n_cmp;
    int         n_fail;
    int         wr_count;
    vec_t       vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.addr = 10'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Reference behaviour for a 10-bit address, 640-word framebuffer.
    task automatic model(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
        int a;
        a = int'({c[3:0], d1}) % 1024;
        case (c[7:4])
            4'h1: if (a < DEPTH) push_wr(a, d2);
            4'h2: m_color = d2;
            4'h3: if (a < DEPTH) begin
                for (int i = 0; i <= int'(d2); i++) begin
                    push_wr(a, m_color);
                    a = (a + 1) % DEPTH;
                end
            end
            4'h4: for (int i = 0; i < DEPTH; i++) push_wr(i, m_color);
            default: ;
        endcase
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
        @(negedge clk);
        cs        = 1'b0;
        command   = c;
        databyte1 = d1;
        databyte2 = d2;
        repeat (4) @(negedge clk);
        cs = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_color = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(we),    0);
        check({tag, "_waddr"}, 32'(waddr), 0);
        check({tag, "_wdata"}, 32'(wdata), 0);
        check({tag, "_score"}, 32'(score), 0);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_err"},   32'(err),   0);
    endtask

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!reset && we) begin
            wr_count++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if (waddr !== e.addr || wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL write_data: got addr %0h data %0h, required addr %0h data %0h",
                             waddr, wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n_wait;
        int base;
        int k;
        int gaps;

        n_cmp     = 0;
        n_fail    = 0;
        wr_count  = 0;
        m_color   = 8'h00;
        reset     = 1'b1;
        cs        = 1'b1;
        command   = 8'h00;
        databyte1 = 8'h00;
        databyte2 = 8'h00;

        vecs[0]  = '{"set_color_0f",  8'h20, 8'h00, 8'h0F, 'h000, 'h0000, 0};
        vecs[1]  = '{"fill_wrap",     8'h32, 8'h7E, 8'h04, 'h000, 'h0000, 0};
        vecs[2]  = '{"set_score",     8'h51, 8'h23, 8'h00, 'h123, 'h0000, 0};
        vecs[3]  = '{"set_state",     8'h60, 8'hBE, 8'hEF, 'h123, 'hBEEF, 0};
        vecs[4]  = '{"nop",           8'h0F, 8'hFF, 8'hFF, 'h123, 'hBEEF, 0};
        vecs[5]  = '{"fill_single",   8'h30, 8'h10, 8'h00, 'h123, 'hBEEF, 0};
        vecs[6]  = '{"write_last",    8'h12, 8'h7F, 8'h55, 'h123, 'hBEEF, 0};
        vecs[7]  = '{"write_trunc",   8'h1E, 8'h05, 8'h77, 'h123, 'hBEEF, 0};
        vecs[8]  = '{"score_trunc",   8'h5F, 8'hFF, 8'h00, 'h3FF, 'hBEEF, 0};
        vecs[9]  = '{"fill_edge",     8'h32, 8'h7F, 8'h01, 'h3FF, 'hBEEF, 0};
        vecs[10] = '{"set_color_c3",  8'h2A, 8'h00, 8'hC3, 'h3FF, 'hBEEF, 0};

        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // WRITE latency: first we exactly three edges after cs is first sampled high.
        model(8'h12, 8'h34, 8'hAB);
        send_frame(8'h12, 8'h34, 8'hAB);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 check("write_lat_early", 32'(we), 0);
        @(posedge clk);
        #1 check("write_lat_we", 32'(we), 1);
        check("write_lat_addr", 32'(waddr), 'h234);
        check("write_lat_data", 32'(wdata), 'hAB);
        @(posedge clk);
        #1 check("write_single", 32'(we), 0);
        check("write_hold_addr", 32'(waddr), 'h234);
        repeat (3) @(negedge clk);
        check("write_drained", exp_q.size(), 0);

        for (int i = 0; i < 11; i++) begin
            model(vecs[i].cmd, vecs[i].db1, vecs[i].db2);
            n_wait = exp_q.size() + 12;
            send_frame(vecs[i].cmd, vecs[i].db1, vecs[i].db2);
            repeat (n_wait) @(negedge clk);
            check({vecs[i].name, "_score"},   32'(score), 32'(vecs[i].exp_score));
            check({vecs[i].name, "_state"},   32'(state), 32'(vecs[i].exp_state));
            check({vecs[i].name, "_err"},     32'(err),   32'(vecs[i].exp_err));
            check({vecs[i].name, "_busy"},    32'(busy),  0);
            check({vecs[i].name, "_drained"}, exp_q.size(), 0);
        end

        // CLEAR with a queued SET_SCORE and a dropped third frame.
        model(8'h40, 8'h00, 8'h00);
        send_frame(8'h40, 8'h00, 8'h00);
        fork
            begin : burst_watch
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!we && k < 20);
                check("clear_start", 32'(we), 1);
                gaps = 0;
                for (int i = 1; i < DEPTH; i++) begin
                    @(negedge clk);
                    if (!we) gaps++;
                    if (i == 300) check("clear_busy", 32'(busy), 1);
                end
                check("clear_contig", gaps, 0);
                @(negedge clk);
                check("clear_end_we", 32'(we), 0);
                check("score_no_gap", 32'(score), 'h321);
            end
            begin : late_frames
                repeat (20) @(negedge clk);
                send_frame(8'h53, 8'h21, 8'h00);
                repeat (20) @(negedge clk);
                send_frame(8'h61, 8'h23, 8'h45);
            end
        join
        repeat (5) @(negedge clk);
        check("drop_err", 32'(err), 1);
        check("drop_state", 32'(state), 'hBEEF);
        check("clear_drained", exp_q.size(), 0);
        check("clear_idle_busy", 32'(busy), 0);

        // Bad opcode: err only, state untouched.
        do_reset();
        send_frame(8'h60, 8'h12, 8'h34);
        repeat (8) @(negedge clk);
        check("pre_bad_state", 32'(state), 'h1234);
        check("pre_bad_err", 32'(err), 0);
        send_frame(8'h9A, 8'h55, 8'h66);
        repeat (8) @(negedge clk);
        check("bad_op_err", 32'(err), 1);
        check("bad_op_state", 32'(state), 'h1234);
        check("bad_op_score", 32'(score), 0);

        // Out-of-range WRITE.
        do_reset();
        send_frame(8'h12, 8'hFF, 8'h11);
        repeat (8) @(negedge clk);
        check("oor_write_err", 32'(err), 1);
        check("oor_write_addr", 32'(waddr), 0);

        // Out-of-range FILL start.
        do_reset();
        send_frame(8'h32, 8'h80, 8'h03);
        repeat (10) @(negedge clk);
        check("oor_fill_err", 32'(err), 1);
        check("oor_fill_busy", 32'(busy), 0);

        // Reset mid-CLEAR at write 100.
        do_reset();
        model(8'h40, 8'h00, 8'h00);
        base = wr_count;
        send_frame(8'h40, 8'h00, 8'h00);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while ((wr_count - base) < 100 && k < 200);
        check("mid_clear_count", wr_count - base, 100);
        #2 reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        m_color = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = wr_count;
        repeat (700) @(negedge clk);
        check("no_resume", wr_count - base, 0);
        check("no_resume_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
